// File: rtl/pp_reorder_buffer.sv
// rtl/pp_reorder_buffer.sv - ping-pong frame reorder buffer; optional macro PP_REORDER_FRAME_CNT_EN adds out_frame_cnt
module pp_reorder_buffer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 128,
  parameter int BITREV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             full,
  output logic             empty
`ifdef PP_REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]      out_frame_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    READY    = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t      bank_state [2];
  logic             wr_bank;
  logic             rd_bank;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [2*DEPTH];

  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic             wr_last;
  logic             rd_last;
  logic             fetch_ok;
  logic             out_load;
  logic             pending;

  function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Write address generation and handshake decode, all from registered state
  always_comb begin
    wr_addr  = (BITREV != 0) ? bit_reverse(wr_ptr) : wr_ptr;
    in_ready = (bank_state[wr_bank] == FREE) || (bank_state[wr_bank] == FILLING);
    wr_en    = in_valid && in_ready;
    wr_last  = (wr_ptr == LAST_ADDR);
    rd_last  = (rd_ptr == LAST_ADDR);
    fetch_ok = (bank_state[rd_bank] == READY) || (bank_state[rd_bank] == DRAINING);
    out_load = !out_valid || out_ready;
    pending  = (bank_state[0] == READY) || (bank_state[0] == DRAINING) ||
               (bank_state[1] == READY) || (bank_state[1] == DRAINING);
    full     = !in_ready;
    empty    = !out_valid && !pending;
  end

  // Sample storage: no reset, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= in_data;
    end
  end

  // Bank state machine, pointers and output register; the write side and
  // read side never touch the same bank on one edge because a bank being
  // filled is never readable and a readable bank never accepts writes
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= FREE;
      bank_state[1] <= FREE;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          bank_state[wr_bank] <= READY;
          wr_bank             <= ~wr_bank;
          wr_ptr              <= '0;
        end else begin
          bank_state[wr_bank] <= FILLING;
          wr_ptr              <= wr_ptr + 1'b1;
        end
      end
      if (out_load) begin
        if (fetch_ok) begin
          out_data  <= mem[{rd_bank, rd_ptr}];
          out_valid <= 1'b1;
          out_last  <= rd_last;
          if (rd_last) begin
            bank_state[rd_bank] <= FREE;
            rd_bank             <= ~rd_bank;
            rd_ptr              <= '0;
          end else begin
            bank_state[rd_bank] <= DRAINING;
            rd_ptr              <= rd_ptr + 1'b1;
          end
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

`ifdef PP_REORDER_FRAME_CNT_EN
  // Completed-frame counter, bumped on the handshake of each final sample
  always_ff @(posedge clk) begin
    if (rst) begin
      out_frame_cnt <= '0;
    end else if (out_valid && out_ready && out_last) begin
      out_frame_cnt <= out_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
